// File: rtl/voice_allocator.sv
// Note-to-voice scheduler: tracks voice ownership, allocates or steals voices and emits DDS/ADSR write strobes.
// Optional feature: define VOICE_ALLOC_RETRIGGER_EN so a note-on for a held note reuses its voice.
module voice_allocator #(
    parameter int unsigned NUM_VOICES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_note_valid,
    output logic        o_note_ready,
    input  logic        i_note_on,
    input  logic [6:0]  i_note_num,
    input  logic [6:0]  i_velocity,
    input  logic [31:0] i_tuning_code,
    output logic [7:0]  o_SPI_voice_index,
    output logic [31:0] o_SPI_tuning_code,
    output logic [6:0]  o_SPI_velocity,
    output logic        o_SPI_note_status,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic [8:0]  o_active_count
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WR_DDS, S_WR_ADSR} state_t;

    state_t                  state_q, state_d;
    logic [NUM_VOICES-1:0]   active_q, active_d;
    logic [6:0]              note_q [NUM_VOICES];
    logic [6:0]              note_d [NUM_VOICES];
    logic [IDX_W-1:0]        steal_q, steal_d;
    logic [IDX_W-1:0]        scan_q, scan_d;
    logic                    match_found_q, match_found_d;
    logic [IDX_W-1:0]        match_idx_q, match_idx_d;
    logic                    free_found_q, free_found_d;
    logic [IDX_W-1:0]        free_idx_q, free_idx_d;
    logic [IDX_W-1:0]        target_q, target_d;
    logic                    ev_on_q, ev_on_d;
    logic [6:0]              ev_num_q, ev_num_d;
    logic [6:0]              ev_vel_q, ev_vel_d;
    logic [31:0]             ev_tune_q, ev_tune_d;
    logic                    ready_q, ready_d;
    logic [7:0]              spi_idx_q, spi_idx_d;
    logic [31:0]             spi_tune_q, spi_tune_d;
    logic [6:0]              spi_vel_q, spi_vel_d;
    logic                    spi_status_q, spi_status_d;
    logic                    flag_dds_q, flag_dds_d;
    logic                    flag_adsr_q, flag_adsr_d;
    logic [8:0]              count_q, count_d;
    logic                    hit_match, hit_free, use_match;

    // State register and all datapath flops
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            active_q      <= '0;
            note_q        <= '{default: '0};
            steal_q       <= '0;
            scan_q        <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            target_q      <= '0;
            ev_on_q       <= 1'b0;
            ev_num_q      <= '0;
            ev_vel_q      <= '0;
            ev_tune_q     <= '0;
            ready_q       <= 1'b0;
            spi_idx_q     <= '0;
            spi_tune_q    <= '0;
            spi_vel_q     <= '0;
            spi_status_q  <= 1'b0;
            flag_dds_q    <= 1'b0;
            flag_adsr_q   <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            note_q        <= note_d;
            steal_q       <= steal_d;
            scan_q        <= scan_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            target_q      <= target_d;
            ev_on_q       <= ev_on_d;
            ev_num_q      <= ev_num_d;
            ev_vel_q      <= ev_vel_d;
            ev_tune_q     <= ev_tune_d;
            ready_q       <= ready_d;
            spi_idx_q     <= spi_idx_d;
            spi_tune_q    <= spi_tune_d;
            spi_vel_q     <= spi_vel_d;
            spi_status_q  <= spi_status_d;
            flag_dds_q    <= flag_dds_d;
            flag_adsr_q   <= flag_adsr_d;
            count_q       <= count_d;
        end
    end

    // Next-state, voice-table update and registered-output computation
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        note_d        = note_q;
        steal_d       = steal_q;
        scan_d        = scan_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        target_d      = target_q;
        ev_on_d       = ev_on_q;
        ev_num_d      = ev_num_q;
        ev_vel_d      = ev_vel_q;
        ev_tune_d     = ev_tune_q;
        spi_idx_d     = spi_idx_q;
        spi_tune_d    = spi_tune_q;
        spi_vel_d     = spi_vel_q;
        spi_status_d  = spi_status_q;
        flag_dds_d    = 1'b0;
        flag_adsr_d   = 1'b0;
        count_d       = count_q;
        use_match     = 1'b0;
        hit_match     = active_q[scan_q] && (note_q[scan_q] == ev_num_q);
        hit_free      = !active_q[scan_q];

        case (state_q)
            S_IDLE: begin
                if (i_note_valid && ready_q) begin
                    ev_on_d       = i_note_on;
                    ev_num_d      = i_note_num;
                    ev_vel_d      = i_velocity;
                    ev_tune_d     = i_tuning_code;
                    scan_d        = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                scan_d = scan_q + 1'b1;
                if (!match_found_q && hit_match) begin
                    match_found_d = 1'b1;
                    match_idx_d   = scan_q;
                end
                if (!free_found_q && hit_free) begin
                    free_found_d = 1'b1;
                    free_idx_d   = scan_q;
                end
                // Decision uses the flags updated with the final voice
                if (scan_q == LAST_IDX) begin
                    if (ev_on_q) begin
`ifdef VOICE_ALLOC_RETRIGGER_EN
                        use_match = match_found_d;
`endif
                        if (use_match) begin
                            target_d = match_idx_d;
                        end else if (free_found_d) begin
                            target_d = free_idx_d;
                            count_d  = count_q + 9'd1;
                        end else begin
                            target_d = steal_q;
                            steal_d  = steal_q + 1'b1;
                        end
                        active_d[target_d] = 1'b1;
                        note_d[target_d]   = ev_num_q;
                        state_d            = S_WR_DDS;
                    end else if (match_found_d) begin
                        target_d           = match_idx_d;
                        active_d[target_d] = 1'b0;
                        count_d            = count_q - 9'd1;
                        state_d            = S_WR_ADSR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_DDS:  state_d = S_WR_ADSR;
            S_WR_ADSR: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        if (state_d == S_WR_DDS) begin
            flag_dds_d = 1'b1;
            spi_idx_d  = 8'(target_d);
            spi_tune_d = ev_tune_q;
        end
        if (state_d == S_WR_ADSR) begin
            flag_adsr_d  = 1'b1;
            spi_idx_d    = 8'(target_d);
            spi_status_d = ev_on_q;
            spi_vel_d    = ev_on_q ? ev_vel_q : 7'd0;
        end
    end

    assign o_note_ready      = ready_q;
    assign o_SPI_voice_index = spi_idx_q;
    assign o_SPI_tuning_code = spi_tune_q;
    assign o_SPI_velocity    = spi_vel_q;
    assign o_SPI_note_status = spi_status_q;
    assign o_SPI_flag_dds    = flag_dds_q;
    assign o_SPI_flag_adsr   = flag_adsr_q;
    assign o_active_count    = count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=16): allocation, release, stealing, drop and reset abort.
module tb_voice_allocator;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_note_valid = 1'b0;
    logic        o_note_ready;
    logic        i_note_on = 1'b0;
    logic [6:0]  i_note_num = '0;
    logic [6:0]  i_velocity = '0;
    logic [31:0] i_tuning_code = '0;
    logic [7:0]  o_SPI_voice_index;
    logic [31:0] o_SPI_tuning_code;
    logic [6:0]  o_SPI_velocity;
    logic        o_SPI_note_status;
    logic        o_SPI_flag_dds;
    logic        o_SPI_flag_adsr;
    logic [8:0]  o_active_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int          dds_n = 0, adsr_n = 0, both_n = 0;
    int          dds_cyc = 0, adsr_cyc = 0;
    logic [7:0]  dds_idx = '0, adsr_idx = '0;
    logic [31:0] dds_tune = '0;
    logic        adsr_status = 1'b0;
    logic [6:0]  adsr_vel = '0;

    voice_allocator #(.NUM_VOICES(16)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_note_valid      (i_note_valid),
        .o_note_ready      (o_note_ready),
        .i_note_on         (i_note_on),
        .i_note_num        (i_note_num),
        .i_velocity        (i_velocity),
        .i_tuning_code     (i_tuning_code),
        .o_SPI_voice_index (o_SPI_voice_index),
        .o_SPI_tuning_code (o_SPI_tuning_code),
        .o_SPI_velocity    (o_SPI_velocity),
        .o_SPI_note_status (o_SPI_note_status),
        .o_SPI_flag_dds    (o_SPI_flag_dds),
        .o_SPI_flag_adsr   (o_SPI_flag_adsr),
        .o_active_count    (o_active_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Strobe recorder, sampled on the falling edge
    always @(negedge i_clk) begin
        if (o_SPI_flag_dds) begin
            dds_n++;
            dds_idx  = o_SPI_voice_index;
            dds_tune = o_SPI_tuning_code;
            dds_cyc  = cyc;
        end
        if (o_SPI_flag_adsr) begin
            adsr_n++;
            adsr_idx    = o_SPI_voice_index;
            adsr_status = o_SPI_note_status;
            adsr_vel    = o_SPI_velocity;
            adsr_cyc    = cyc;
        end
        if (o_SPI_flag_dds && o_SPI_flag_adsr) both_n++;
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_note_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic send(input logic on, input logic [6:0] num, input logic [6:0] vel,
                        input logic [31:0] tune, output int acc);
        int k = 0;
        while (!o_note_ready && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        if (!o_note_ready) begin
            tests++;
            fails++;
            $display("FAIL send_ready_timeout: ready=%b required 1", o_note_ready);
        end
        i_note_valid  = 1'b1;
        i_note_on     = on;
        i_note_num    = num;
        i_velocity    = vel;
        i_tuning_code = tune;
        @(posedge i_clk);
        @(negedge i_clk);
        acc = cyc;
        i_note_valid = 1'b0;
    endtask

    task automatic wait_idle(output int rc);
        int k = 0;
        while (!o_note_ready && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        rc = cyc;
        if (!o_note_ready) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: ready=%b required 1", o_note_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        tests++;
        if (o_note_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_held: got %b want 0", o_note_ready); end
        i_reset = 1'b0;
        @(negedge i_clk);
        tests++;
        if (o_note_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", o_note_ready); end
        tests++;
        if ({o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity, o_SPI_note_status,
             o_SPI_flag_dds, o_SPI_flag_adsr} !== '0) begin
            fails++;
            $display("FAIL reset_spi: idx=%0d tune=%h vel=%0d st=%b dds=%b adsr=%b want all 0",
                     o_SPI_voice_index, o_SPI_tuning_code, o_SPI_velocity, o_SPI_note_status,
                     o_SPI_flag_dds, o_SPI_flag_adsr);
        end
        tests++;
        if (o_active_count !== 9'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_active_count); end
    endtask

    task automatic test_note_on();
        int acc, rc;
        do_reset();
        send(1'b1, 7'd60, 7'd100, 32'h01234567, acc);
        wait_idle(rc);
        tests++;
        if (dds_cyc !== acc + 16) begin fails++; $display("FAIL on_dds_time: got %0d want %0d", dds_cyc - acc, 16); end
        tests++;
        if (dds_idx !== 8'd0) begin fails++; $display("FAIL on_dds_idx: got %0d want 0", dds_idx); end
        tests++;
        if (dds_tune !== 32'h01234567) begin fails++; $display("FAIL on_dds_tune: got %h want 01234567", dds_tune); end
        tests++;
        if (adsr_cyc !== acc + 17) begin fails++; $display("FAIL on_adsr_time: got %0d want %0d", adsr_cyc - acc, 17); end
        tests++;
        if (adsr_status !== 1'b1 || adsr_vel !== 7'd100 || adsr_idx !== 8'd0) begin
            fails++;
            $display("FAIL on_adsr_data: st=%b vel=%0d idx=%0d want 1/100/0", adsr_status, adsr_vel, adsr_idx);
        end
        tests++;
        if (rc !== acc + 18) begin fails++; $display("FAIL on_ready_time: got %0d want %0d", rc - acc, 18); end
        tests++;
        if (o_active_count !== 9'd1) begin fails++; $display("FAIL on_count: got %0d want 1", o_active_count); end
    endtask

    task automatic test_note_off();
        int acc, rc, d0, a0;
        do_reset();
        send(1'b1, 7'd60, 7'd90, 32'h00001111, acc);
        wait_idle(rc);
        send(1'b1, 7'd62, 7'd91, 32'h00002222, acc);
        wait_idle(rc);
        d0 = dds_n;
        a0 = adsr_n;
        send(1'b0, 7'd60, 7'd55, 32'hDEADBEEF, acc);
        wait_idle(rc);
        tests++;
        if (dds_n - d0 !== 0 || adsr_n - a0 !== 1) begin
            fails++;
            $display("FAIL off_strobes: dds=%0d adsr=%0d want 0/1", dds_n - d0, adsr_n - a0);
        end
        tests++;
        if (adsr_idx !== 8'd0 || adsr_status !== 1'b0 || adsr_vel !== 7'd0) begin
            fails++;
            $display("FAIL off_data: idx=%0d st=%b vel=%0d want 0/0/0", adsr_idx, adsr_status, adsr_vel);
        end
        tests++;
        if (adsr_cyc !== acc + 16 || rc !== acc + 17) begin
            fails++;
            $display("FAIL off_timing: adsr=%0d ready=%0d want 16/17", adsr_cyc - acc, rc - acc);
        end
        tests++;
        if (o_active_count !== 9'd1) begin fails++; $display("FAIL off_count: got %0d want 1", o_active_count); end
        send(1'b1, 7'd64, 7'd80, 32'h00003333, acc);
        wait_idle(rc);
        tests++;
        if (dds_idx !== 8'd0 || dds_tune !== 32'h00003333) begin
            fails++;
            $display("FAIL off_reuse: idx=%0d tune=%h want 0/00003333", dds_idx, dds_tune);
        end
        tests++;
        if (o_active_count !== 9'd2) begin fails++; $display("FAIL off_reuse_count: got %0d want 2", o_active_count); end
    endtask

    task automatic test_steal();
        int acc, rc;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 7'(40 + i), 7'd64, 32'(i + 1), acc);
            wait_idle(rc);
        end
        tests++;
        if (dds_idx !== 8'd15 || o_active_count !== 9'd16) begin
            fails++;
            $display("FAIL fill: idx=%0d count=%0d want 15/16", dds_idx, o_active_count);
        end
        send(1'b1, 7'd70, 7'd64, 32'h70, acc);
        wait_idle(rc);
        tests++;
        if (dds_idx !== 8'd0 || o_active_count !== 9'd16) begin
            fails++;
            $display("FAIL steal_first: idx=%0d count=%0d want 0/16", dds_idx, o_active_count);
        end
        send(1'b1, 7'd71, 7'd64, 32'h71, acc);
        wait_idle(rc);
        tests++;
        if (dds_idx !== 8'd1 || o_active_count !== 9'd16) begin
            fails++;
            $display("FAIL steal_second: idx=%0d count=%0d want 1/16", dds_idx, o_active_count);
        end
    endtask

    task automatic test_drop();
        int acc, rc, d0, a0;
        do_reset();
        send(1'b1, 7'd60, 7'd100, 32'h1, acc);
        wait_idle(rc);
        d0 = dds_n;
        a0 = adsr_n;
        send(1'b0, 7'd99, 7'd0, 32'h0, acc);
        wait_idle(rc);
        tests++;
        if (dds_n - d0 !== 0 || adsr_n - a0 !== 0) begin
            fails++;
            $display("FAIL drop_strobes: dds=%0d adsr=%0d want 0/0", dds_n - d0, adsr_n - a0);
        end
        tests++;
        if (rc !== acc + 16) begin fails++; $display("FAIL drop_ready_time: got %0d want 16", rc - acc); end
        tests++;
        if (o_active_count !== 9'd1) begin fails++; $display("FAIL drop_count: got %0d want 1", o_active_count); end
    endtask

    task automatic test_duplicate();
        int acc, rc;
        logic [7:0] want_idx;
        logic [8:0] want_cnt;
`ifdef VOICE_ALLOC_RETRIGGER_EN
        want_idx = 8'd0;
        want_cnt = 9'd1;
`else
        want_idx = 8'd1;
        want_cnt = 9'd2;
`endif
        do_reset();
        send(1'b1, 7'd60, 7'd100, 32'hAAAA0000, acc);
        wait_idle(rc);
        send(1'b1, 7'd60, 7'd50, 32'hBBBB0000, acc);
        wait_idle(rc);
        tests++;
        if (dds_idx !== want_idx || dds_tune !== 32'hBBBB0000 || adsr_vel !== 7'd50 || adsr_status !== 1'b1) begin
            fails++;
            $display("FAIL dup_target: idx=%0d tune=%h vel=%0d st=%b want %0d/bbbb0000/50/1",
                     dds_idx, dds_tune, adsr_vel, adsr_status, want_idx);
        end
        tests++;
        if (o_active_count !== want_cnt) begin fails++; $display("FAIL dup_count: got %0d want %0d", o_active_count, want_cnt); end
        send(1'b0, 7'd60, 7'd0, 32'h0, acc);
        wait_idle(rc);
        tests++;
        if (adsr_idx !== 8'd0 || o_active_count !== want_cnt - 9'd1) begin
            fails++;
            $display("FAIL dup_release: idx=%0d count=%0d want 0/%0d", adsr_idx, o_active_count, want_cnt - 9'd1);
        end
    endtask

    task automatic test_reset_mid();
        int acc, rc, d0, a0;
        do_reset();
        send(1'b1, 7'd60, 7'd100, 32'h5, acc);
        wait_idle(rc);
        send(1'b1, 7'd61, 7'd100, 32'h6, acc);
        d0 = dds_n;
        a0 = adsr_n;
        repeat (5) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        tests++;
        if (o_note_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_in_reset: got %b want 0", o_note_ready); end
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (25) @(negedge i_clk);
        tests++;
        if (dds_n - d0 !== 0 || adsr_n - a0 !== 0) begin
            fails++;
            $display("FAIL mid_strobes: dds=%0d adsr=%0d want 0/0", dds_n - d0, adsr_n - a0);
        end
        tests++;
        if (o_active_count !== 9'd0 || o_note_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_after: count=%0d ready=%b want 0/1", o_active_count, o_note_ready);
        end
        send(1'b1, 7'd61, 7'd100, 32'h7, acc);
        wait_idle(rc);
        tests++;
        if (dds_idx !== 8'd0 || o_active_count !== 9'd1) begin
            fails++;
            $display("FAIL mid_table_cleared: idx=%0d count=%0d want 0/1", dds_idx, o_active_count);
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_note_off();
        test_steal();
        test_drop();
        test_duplicate();
        test_reset_mid();
        tests++;
        if (both_n !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", both_n); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Note-to-voice scheduler sitting between the MIDI/SPI command decoder and the voice pipeline's DDS/ADSR register-write ports. Accepts note-on/note-off events over a valid/ready handshake, tracks which note owns each voice, picks a free voice (or steals one round-robin when none is free) and emits the one-cycle write strobes that load tuning code, velocity and gate state into the shared voice pipeline. Sole writer of the pipeline's SPI-side inputs.

## Interface
- NUM_VOICES, 16, voices managed; power of two, 2..256; voice indices 0..NUM_VOICES-1
- i_clk  in  1  clock
- i_reset  in  1  reset; synchronous, active-high; clock i_clk
- i_note_valid  in  1  event present
- o_note_ready  out  1  event accepted when valid&&ready
- i_note_on  in  1  1 = note-on, 0 = note-off
- i_note_num  in  7  MIDI note number
- i_velocity  in  7  velocity; used on note-on only
- i_tuning_code  in  32  DDS tuning word for i_note_num; used on note-on only
- o_SPI_voice_index  out  8  target voice
- o_SPI_tuning_code  out  32  tuning word to DDS
- o_SPI_velocity  out  7  velocity to ADSR
- o_SPI_note_status  out  1  gate to ADSR: 1 = on, 0 = off
- o_SPI_flag_dds  out  1  one-cycle DDS write strobe
- o_SPI_flag_adsr  out  1  one-cycle ADSR write strobe
- o_active_count  out  9  number of voices marked active

## Operation
- Voice table per voice: active bit, 7-bit note. Steal pointer steal_ptr (log2 NUM_VOICES bits).
- States: IDLE, SCAN, WR_DDS, WR_ADSR.
- IDLE: o_note_ready=1. On handshake, latch event fields, clear scan counter and match/free found flags, go SCAN.
- SCAN: one voice per cycle, index 0 upward, exactly NUM_VOICES cycles. Record lowest-index active voice with matching note ("match") and lowest-index inactive voice ("free").
- End of SCAN, note-on: target = match (retrigger, see Configuration), else free, else steal_ptr (steal_ptr increments, wraps to 0). Target marked active with new note. Go WR_DDS.
- End of SCAN, note-off: match found -> target = match, mark inactive, go WR_ADSR; none -> drop event, go IDLE, no strobes.
- WR_DDS: o_SPI_flag_dds=1, voice index and tuning code valid. Go WR_ADSR.
- WR_ADSR: o_SPI_flag_adsr=1, note_status = latched i_note_on, velocity valid (0 on note-off). Go IDLE.
- o_SPI_* data outputs hold last written values between strobes.
- o_active_count: registered, updated in the cycle the table bit changes; steal and retrigger leave it unchanged.
- Voice freed at note-off; release tail may be stolen by a later note-on.

## Timing
- Reset: state IDLE, table cleared, steal_ptr=0, all o_SPI_* = 0, o_active_count=0, o_note_ready=0 while i_reset high, 1 first cycle after.
- Handshake at cycle T; SCAN T+1..T+NUM_VOICES; note-on: flag_dds at T+NUM_VOICES+1, flag_adsr at T+NUM_VOICES+2, ready at T+NUM_VOICES+3.
- Note-off with match: flag_adsr at T+NUM_VOICES+1, ready at T+NUM_VOICES+2. Dropped note-off: ready at T+NUM_VOICES+1.
- o_note_ready low outside IDLE; event fields ignored then.
- Strobes never both high same cycle; never consecutive events without an IDLE cycle.
- Reset mid-operation: aborts; no further strobes; table cleared.

## Configuration
- VOICE_ALLOC_RETRIGGER_EN defined: note-on for a held note reuses its matching voice (new tuning/velocity, gate re-asserted), count unchanged.
- Undefined: match ignored on note-on; duplicate note gets a new voice. Note-off always releases lowest-index match only.

## Test plan
- Reset, NUM_VOICES=16 -> all o_SPI_*=0, count=0, ready=1 cycle after reset release.
- Note-on 60, vel 100, tuning 0x01234567 at T -> flag_dds T+17 voice 0 tuning 0x01234567; flag_adsr T+18 status 1 vel 100; count=1; ready T+19.
- Note-on 60 then 62, note-off 60 -> flag_adsr voice 0 status 0, no flag_dds; count=1; next note-on 64 gets voice 0.
- 16 note-ons 40..55 then note-on 70 -> voice 0 stolen (count 16), next note-on 71 steals voice 1.
- Note-off 99 never played -> no strobes, ready at T+17; count unchanged.
- Note-on 60 twice: macro on -> both voice 0, count=1; off -> voices 0,1, count=2. Reset asserted mid-SCAN -> no strobes, count=0.
